exp_rr_arbiter: RTL and testbench

- Shares one combinational exponent unit (17-bit x in, 21-bit {position[4:0], mantissa[15:0]} out) among NREQ softmax lanes.
- Round-robin arbitration with per-lane valid/ready request and response handshakes.
- Two-stage registered pipeline around the exp unit: issue register, then result register.
- Sits between the lane input buffers and the normalisation/accumulate stage.

---
 rtl/exp_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_exp_rr_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_rr_arbiter.sv
// rtl/exp_rr_arbiter.sv - round-robin arbiter sharing one exp unit across softmax lanes
module exp_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int XW   = 17,
  parameter int EW   = 21,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      lane_en,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*XW-1:0]   req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic [XW-1:0]        exp_x,
  input  logic [EW-1:0]        exp_y,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [EW-1:0]        rsp_data,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic                 busy,
  output logic [15:0]          issued_cnt
);

  // Issue stage (S1) feeds the exp unit; result stage (S2) holds the answer for one lane.
  logic            s1_v_q, s1_v_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic [XW-1:0]   s1_x_q, s1_x_d;
  logic            s2_v_q, s2_v_d;
  logic [IDW-1:0]  s2_id_q, s2_id_d;
  logic [EW-1:0]   s2_y_q, s2_y_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [15:0]     cnt_q, cnt_d;

  logic              s2_rdy;
  logic              s2_adv;
  logic              s1_adv;
  logic [NREQ-1:0]   eligible;
  logic [2*NREQ-1:0] elig_rot;
  logic              found;
  logic [IDW:0]      win_sum;
  logic [IDW-1:0]    winner;
  logic              grant;
  logic [XW-1:0]     win_x;
  logic [IDW:0]      ptr_next;

  // Only the lane that owns the S2 result can release the pipeline.
  always_comb begin
    s2_rdy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (s2_id_q == IDW'(i)) s2_rdy = rsp_ready[i];
    end
    s2_adv = !s2_v_q || s2_rdy;
    s1_adv = !s1_v_q || s2_adv;
  end

  // Rotate eligibility so bit 0 is the pointer lane, then take the first set bit.
  always_comb begin
    eligible = req_valid & lane_en;
    elig_rot = {eligible, eligible} >> ptr_q;
    found    = 1'b0;
    win_sum  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        found   = 1'b1;
        win_sum = {1'b0, ptr_q} + (IDW+1)'(k);
      end
    end
    if (win_sum >= (IDW+1)'(NREQ)) win_sum = win_sum - (IDW+1)'(NREQ);
    winner = win_sum[IDW-1:0];
    // Reset masks the grant so req_ready also drops asynchronously.
    grant     = found && s1_adv && !rst;
    req_ready = grant ? (NREQ'(1) << winner) : '0;
  end

  // Pick the winning lane's operand out of the packed request bus.
  always_comb begin
    win_x = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) win_x = req_x[i*XW +: XW];
    end
  end

  // Next-state: S2 drains/refills, S1 takes the new grant, pointer moves past the winner.
  always_comb begin
    s1_v_d   = s1_v_q;
    s1_id_d  = s1_id_q;
    s1_x_d   = s1_x_q;
    s2_v_d   = s2_v_q;
    s2_id_d  = s2_id_q;
    s2_y_d   = s2_y_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ptr_next = {1'b0, winner} + 1'b1;
    if (ptr_next == (IDW+1)'(NREQ)) ptr_next = '0;

    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_id_d = s1_id_q;
        s2_y_d  = exp_y;
      end
    end

    if (s1_adv) begin
      if (grant) begin
        s1_v_d  = 1'b1;
        s1_id_d = winner;
        s1_x_d  = win_x;
        ptr_d   = ptr_next[IDW-1:0];
        cnt_d   = cnt_q + 16'd1;
      end else begin
        // Operand is left in place so exp_x does not toggle on idle cycles.
        s1_v_d = 1'b0;
      end
    end
  end

  // Pipeline and arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s1_id_q <= '0;
      s1_x_q  <= '0;
      s2_v_q  <= 1'b0;
      s2_id_q <= '0;
      s2_y_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_id_q <= s1_id_d;
      s1_x_q  <= s1_x_d;
      s2_v_q  <= s2_v_d;
      s2_id_q <= s2_id_d;
      s2_y_q  <= s2_y_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response decode and status outputs.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = s2_v_q && (s2_id_q == IDW'(i));
    end
  end

  assign exp_x      = s1_x_q;
  assign rsp_data   = s2_y_q;
  assign busy       = s1_v_q | s2_v_q;
  assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_exp_rr_arbiter.sv
// tb/tb_exp_rr_arbiter.sv - scoreboard bench for exp_rr_arbiter
module tb_exp_rr_arbiter;
  localparam int NREQ = 4;
  localparam int XW   = 17;
  localparam int EW   = 21;
  localparam int IDW  = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     lane_en = '0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*XW-1:0]  req_x = '0;
  logic [NREQ-1:0]     req_ready;
  logic [XW-1:0]       exp_x;
  logic [EW-1:0]       exp_y;
  logic [NREQ-1:0]     rsp_valid;
  logic [EW-1:0]       rsp_data;
  logic [NREQ-1:0]     rsp_ready = '1;
  logic                busy;
  logic [15:0]         issued_cnt;

  exp_rr_arbiter #(.NREQ(NREQ), .XW(XW), .EW(EW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .lane_en(lane_en), .req_valid(req_valid), .req_x(req_x),
    .req_ready(req_ready), .exp_x(exp_x), .exp_y(exp_y), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in exp unit: any deterministic function of x lets results be traced to their operand.
  function automatic logic [EW-1:0] exp_fn(logic [XW-1:0] x);
    return {x[4:0] ^ x[16:12], x[15:0] ^ {x[11:0], x[16:13]}};
  endfunction

  assign exp_y = exp_fn(exp_x);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference: a two-deep in-order pipe where a result is visible once it is two cycles old.
  typedef struct { int lane; logic [XW-1:0] x; int age; } item_t;
  typedef struct { int lane; logic [EW-1:0] y; } rsp_t;
  item_t pipe[$];
  rsp_t  sb[$];
  int            m_ptr = 0;
  logic [15:0]   m_cnt = '0;
  logic [XW-1:0] m_last_x = '0;

  always @(negedge clk) begin : model_b
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] want_rr;
    logic [NREQ-1:0] want_rv;
    bit              head_vis;
    bit              stalled;
    bit              accept;
    int              w;
    item_t           it;
    rsp_t            r;
    if (rst) begin
      pipe.delete();
      sb.delete();
      m_ptr = 0;
      m_cnt = '0;
      m_last_x = '0;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_issued_cnt", 32'(issued_cnt), 32'd0);
      check("rst_exp_x", 32'(exp_x), 32'd0);
    end else begin
      head_vis = (pipe.size() > 0) && (pipe[0].age >= 2);
      want_rv  = head_vis ? (NREQ'(1) << pipe[0].lane) : '0;
      stalled  = head_vis && !rsp_ready[pipe[0].lane];
      accept   = !(pipe.size() == 2 && stalled);
      elig     = req_valid & lane_en;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && elig[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      want_rr = (accept && w >= 0) ? (NREQ'(1) << w) : '0;
      check("req_ready", 32'(req_ready), 32'(want_rr));
      check("rsp_valid", 32'(rsp_valid), 32'(want_rv));
      check("busy", 32'(busy), 32'(pipe.size() != 0));
      check("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
      check("exp_x", 32'(exp_x), 32'(m_last_x));
      if (head_vis && !stalled) void'(pipe.pop_front());
      foreach (pipe[i]) pipe[i].age++;
      if (want_rr != '0) begin
        it.lane = w;
        it.x    = req_x[w*XW +: XW];
        it.age  = 1;
        pipe.push_back(it);
        r.lane = w;
        r.y    = exp_fn(it.x);
        sb.push_back(r);
        m_ptr    = (w + 1) % NREQ;
        m_cnt    = m_cnt + 16'd1;
        m_last_x = it.x;
      end
    end
  end

  // Monitor: each presented response must match the oldest outstanding grant.
  always @(negedge clk) begin
    if (!rst && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        check("sb_lane", 32'(rsp_valid), 32'(NREQ'(1) << sb[0].lane));
        check("sb_data", 32'(rsp_data), 32'(sb[0].y));
        if (rsp_ready[sb[0].lane]) void'(sb.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_x();
    for (int i = 0; i < NREQ; i++) req_x[i*XW +: XW] = XW'($urandom_range(0, (1 << XW) - 1));
  endtask

  logic [XW-1:0] hold_x;
  int            spin;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    next_cycle();

    // Single request on lane 0 with x = +1.0.
    lane_en = 4'b1111;
    rsp_ready = 4'b1111;
    req_x[0 +: XW] = 17'h01000;
    req_valid = 4'b0001;
    @(negedge clk) check("t1_grant", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = '0;
    @(negedge clk) check("t1_exp_x", 32'(exp_x), 32'h01000);
    @(negedge clk);
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_rsp_data", 32'(rsp_data), 32'(exp_fn(17'h01000)));
    check("t1_issued_cnt", 32'(issued_cnt), 32'd1);

    // All lanes continuously valid: rotation starts just past lane 0.
    next_cycle();
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      rand_x();
      @(negedge clk) check("rr_order", 32'(req_ready), 32'(4'b0001 << ((1 + i) % NREQ)));
      next_cycle();
    end
    req_valid = '0;
    repeat (4) next_cycle();

    // Lanes 0 and 2 requesting while lane 2 refuses its result.
    rand_x();
    hold_x = req_x[0 +: XW];
    rsp_ready = 4'b1011;
    req_valid = 4'b0101;
    repeat (2) next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_exp_x", 32'(exp_x), 32'(hold_x));
      check("stall_rsp_valid", 32'(rsp_valid), 32'b0100);
      next_cycle();
    end
    req_valid = '0;
    rsp_ready = 4'b1111;
    repeat (4) next_cycle();

    // Lane 2 masked off: it must never be granted.
    lane_en = 4'b1011;
    req_valid = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      rand_x();
      @(negedge clk) check("masked_lane2", 32'(req_ready[2]), 32'd0);
      next_cycle();
    end

    // Randomized traffic, enables and back-pressure.
    for (int i = 0; i < 1500; i++) begin
      rand_x();
      req_valid = NREQ'($urandom_range(0, 15));
      lane_en   = ($urandom_range(0, 3) == 0) ? NREQ'($urandom_range(0, 15)) : 4'b1111;
      for (int j = 0; j < NREQ; j++) rsp_ready[j] = ($urandom_range(0, 9) < 7);
      next_cycle();
    end
    req_valid = '0;
    rsp_ready = 4'b1111;
    lane_en = 4'b1111;
    repeat (4) next_cycle();

    // Reset while a -1.0 request is in flight on lane 3.
    req_x[3*XW +: XW] = 17'h11000;
    req_valid = 4'b1000;
    next_cycle();
    req_valid = '0;
    #1 rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_issued_cnt", 32'(issued_cnt), 32'd0);
    check("midrst_exp_x", 32'(exp_x), 32'd0);
    next_cycle();
    rst = 1'b0;
    lane_en = 4'b0110;
    req_valid = 4'b1111;
    @(negedge clk) check("postrst_grant", 32'(req_ready), 32'b0010);
    next_cycle();
    req_valid = '0;
    lane_en = 4'b1111;
    repeat (4) next_cycle();

    // Counter wrap: 65537 grants from a fresh reset leave issued_cnt at 1.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    lane_en = 4'b0001;
    req_valid = 4'b0001;
    repeat (65537) @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk) check("wrap_issued_cnt", 32'(issued_cnt), 32'd1);

    // Drain with a bounded wait.
    lane_en = 4'b1111;
    spin = 0;
    while ((pipe.size() != 0 || sb.size() != 0) && spin < 20) begin
      next_cycle();
      spin++;
    end
    @(negedge clk);
    check("drain_outstanding", 32'(pipe.size() + sb.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
